// File: rtl/systolic_tile_scheduler.sv
// Purpose : sequences one full tiled matrix multiply over the systolic array and its data_gen feeder.
// Latency : INIT->REQ->WAIT per slice, next REQ one cycle after the later slice-done; NEXT adds 1 cycle per tile.
// Backpressure: waits indefinitely on slice-done strobes; result drain is bounded by DRAIN_TIMEOUT idle cycles.
//
// Ports:
//   s_clk, s_rst             clock, asynchronous active-low reset
//   i_start, i_abort         run control from the layer FSM (start sampled in IDLE only, abort wins always)
//   i_cfg_{m,n,k}_*          tile rows / tile columns / slices per tile, latched at start
//   o_init_prepare           one-cycle init pulse per tile to data_gen / array
//   o_slice_req, o_k_idx,    one-cycle slice request with its slice index and last-slice flag
//   o_k_last
//   o_m_idx, o_n_idx         current output tile coordinates
//   i_Mtrx{A,B}_slice_done   slice fully consumed strobes
//   i_result_*, o_result_ready  result drain handshake
//   o_busy, o_done, o_err_timeout  status

module systolic_tile_scheduler #(
  parameter int CNT_W         = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             s_clk,
  input  logic             s_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_cfg_m_tiles,
  input  logic [CNT_W-1:0] i_cfg_n_tiles,
  input  logic [CNT_W-1:0] i_cfg_k_slices,
  output logic             o_init_prepare,
  output logic             o_slice_req,
  output logic [CNT_W-1:0] o_m_idx,
  output logic [CNT_W-1:0] o_n_idx,
  output logic [CNT_W-1:0] o_k_idx,
  output logic             o_k_last,
  input  logic             i_MtrxA_slice_done,
  input  logic             i_MtrxB_slice_done,
  input  logic             i_result_valid,
  input  logic             i_result_last,
  output logic             o_result_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err_timeout
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, INIT, REQ, WAIT_SLICE, DRAIN, NEXT, DONE
  } stateT;

  stateT state;
  stateT nextState;

  logic [CNT_W-1:0] mCfg, nCfg, kCfg;
  logic [CNT_W-1:0] mIdx, nIdx, kIdx;
  logic             aSeen, bSeen;
  logic [TW-1:0]    drainCnt;
  logic             errTimeout;

  logic cfgZero;
  logic aNow, bNow, bothSeen;
  logic kAtLast, nAtLast, mAtLast;
  logic resultReady, beatAccept, drainExpire;

  // Last-index compares use the latched config minus one; a zero config never
  // reaches these because IDLE sends it straight to DONE.
  assign cfgZero  = (i_cfg_m_tiles == '0) || (i_cfg_n_tiles == '0) || (i_cfg_k_slices == '0);
  assign kAtLast  = (kIdx == kCfg - 1'b1);
  assign nAtLast  = (nIdx == nCfg - 1'b1);
  assign mAtLast  = (mIdx == mCfg - 1'b1);

  // The strobe arriving this cycle is ORed in so the scheduler moves on in the
  // same cycle the second strobe shows up.
  assign aNow     = aSeen | i_MtrxA_slice_done;
  assign bNow     = bSeen | i_MtrxB_slice_done;
  assign bothSeen = aNow & bNow;

  // Ready is withheld during abort so no beat is consumed by a run being torn down.
  assign resultReady = (state == DRAIN) && !i_abort;
  assign beatAccept  = i_result_valid && resultReady;
  assign drainExpire = (state == DRAIN) && !beatAccept && (drainCnt == TW'(DRAIN_TIMEOUT - 1));

  // State register
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    if (i_abort) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:       if (i_start) nextState = cfgZero ? DONE : INIT;
        INIT:       nextState = REQ;
        REQ:        nextState = WAIT_SLICE;
        WAIT_SLICE: if (bothSeen) nextState = kAtLast ? DRAIN : REQ;
        DRAIN:      if ((beatAccept && i_result_last) || drainExpire) nextState = NEXT;
        NEXT:       nextState = (nAtLast && mAtLast) ? DONE : INIT;
        DONE:       nextState = IDLE;
        default:    nextState = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_init_prepare = (state == INIT) && !i_abort;
    o_slice_req    = (state == REQ) && !i_abort;
    o_k_last       = (state == REQ) && !i_abort && kAtLast;
    o_done         = (state == DONE) && !i_abort;
    o_result_ready = resultReady;
    o_busy         = (state != IDLE);
  end

  assign o_m_idx       = mIdx;
  assign o_n_idx       = nIdx;
  assign o_k_idx       = kIdx;
  assign o_err_timeout = errTimeout;

  // Config, tile/slice counters, slice-done flags and drain watchdog
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      mCfg       <= '0;
      nCfg       <= '0;
      kCfg       <= '0;
      mIdx       <= '0;
      nIdx       <= '0;
      kIdx       <= '0;
      aSeen      <= 1'b0;
      bSeen      <= 1'b0;
      drainCnt   <= '0;
      errTimeout <= 1'b0;
    end else if (i_abort) begin
      // Counters hold so the abort point stays visible; only the flags drop.
      aSeen    <= 1'b0;
      bSeen    <= 1'b0;
      drainCnt <= '0;
    end else begin
      // Watchdog counts consecutive DRAIN cycles without an accepted beat.
      if ((state == DRAIN) && !beatAccept) begin
        drainCnt <= drainCnt + 1'b1;
      end else begin
        drainCnt <= '0;
      end

      if (drainExpire) begin
        errTimeout <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            mCfg       <= i_cfg_m_tiles;
            nCfg       <= i_cfg_n_tiles;
            kCfg       <= i_cfg_k_slices;
            mIdx       <= '0;
            nIdx       <= '0;
            kIdx       <= '0;
            errTimeout <= 1'b0;
          end
        end
        // A strobe landing in the request cycle itself is remembered too.
        REQ: begin
          aSeen <= aNow;
          bSeen <= bNow;
        end
        WAIT_SLICE: begin
          if (bothSeen) begin
            aSeen <= 1'b0;
            bSeen <= 1'b0;
            kIdx  <= kAtLast ? '0 : kIdx + 1'b1;
          end else begin
            aSeen <= aNow;
            bSeen <= bNow;
          end
        end
        NEXT: begin
          if (!nAtLast) begin
            nIdx <= nIdx + 1'b1;
          end else begin
            nIdx <= '0;
            if (!mAtLast) begin
              mIdx <= mIdx + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
